// File: rtl/tug_key_pulser.sv
// Tug-of-war key front end: sync, debounce and press FSM per player key.
// Emits one registered single-cycle L/R strobe per debounced press.
module tug_key_pulser #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic game_over,
  output logic L,
  output logic R
);

  typedef enum logic [1:0] {
    WAIT_RELEASE,
    IDLE,
    HELD
  } state_t;

  // Released must be seen long enough to flush the synchroniser too
  localparam int REL = DEBOUNCE_CYCLES + 2;
  localparam int RW  = $clog2(REL + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]    REL_LAST = RW'(REL - 1);

  logic [1:0]       key_n;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       pressed;
  logic [1:0]       deb;
  logic [CNT_W-1:0] cnt [2];
  logic [RW-1:0]    rel_q [2];
  logic [RW-1:0]    rel_d [2];
  state_t           st_q [2];
  state_t           st_d [2];
  logic [1:0]       strobe_q;
  logic [1:0]       strobe_d;
  logic             go_q;
  logic             go_rise;

  assign key_n   = {key_r_n, key_l_n};
  assign pressed = ~s2;
  assign go_rise = game_over & ~go_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= '1;
      s2  <= '1;
      deb <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= key_n;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= pressed[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q     <= 1'b0;
      strobe_q <= '0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= WAIT_RELEASE;
        rel_q[i] <= '0;
      end
    end else begin
      go_q     <= game_over;
      strobe_q <= strobe_d;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        rel_q[i] <= rel_d[i];
      end
    end
  end

  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      rel_d[i] = '0;
      unique case (st_q[i])
        WAIT_RELEASE: begin
          if (!pressed[i] && !deb[i]) begin
            if (rel_q[i] == REL_LAST) begin
              st_d[i] = IDLE;
            end else begin
              rel_d[i] = rel_q[i] + RW'(1);
            end
          end
        end
        IDLE: begin
          if (deb[i]) begin
            st_d[i]     = HELD;
            strobe_d[i] = ~game_over;
          end
        end
        HELD: begin
          if (go_rise) begin
            st_d[i] = WAIT_RELEASE;
          end else if (!deb[i]) begin
            st_d[i] = IDLE;
          end
        end
        default: st_d[i] = WAIT_RELEASE;
      endcase
    end
  end

  assign L = strobe_q[0];
  assign R = strobe_q[1];

endmodule

// File: tb/tb_tug_key_pulser.sv
// Directed vector bench for tug_key_pulser.
// Inputs and checks happen on the falling clock edge.
module tb_tug_key_pulser;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_l_n = 1'b1;
  logic key_r_n = 1'b1;
  logic game_over = 1'b0;
  logic L;
  logic R;

  tug_key_pulser dut (
    .clk       (clk),
    .reset     (reset),
    .key_l_n   (key_l_n),
    .key_r_n   (key_r_n),
    .game_over (game_over),
    .L         (L),
    .R         (R)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic kl;
    logic kr;
    logic go;
    logic rst;
    logic el;
    logic er;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(int n, logic kl, logic kr,
                              logic go, logic rst);
    vec_t v;
    v.kl  = kl;
    v.kr  = kr;
    v.go  = go;
    v.rst = rst;
    v.el  = 1'b0;
    v.er  = 1'b0;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  function automatic void mark(int idx, logic l, logic r);
    vec_t v;
    v = vq[idx];
    if (l) v.el = 1'b1;
    if (r) v.er = 1'b1;
    vq[idx] = v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int k;
    int k2;
    int first;
    int hits;

    // 1: reset then idle
    add(2, 1, 1, 0, 1);
    add(8, 1, 1, 0, 0);
    // 2: clean left press
    k = vq.size();
    add(20, 0, 1, 0, 0);
    mark(k + 6, 1, 0);
    add(12, 1, 1, 0, 0);
    // 3: bouncy right, then clean right
    add(3, 1, 0, 0, 0);
    add(2, 1, 1, 0, 0);
    add(3, 1, 0, 0, 0);
    add(10, 1, 1, 0, 0);
    k = vq.size();
    add(10, 1, 0, 0, 0);
    mark(k + 6, 0, 1);
    add(12, 1, 1, 0, 0);
    // 4: simultaneous
    k = vq.size();
    add(10, 0, 0, 0, 0);
    mark(k + 6, 1, 1);
    add(12, 1, 1, 0, 0);
    // 5: press under game_over, held across its fall
    add(1, 1, 1, 1, 0);
    add(10, 0, 1, 1, 0);
    add(5, 0, 1, 0, 0);
    add(12, 1, 1, 0, 0);
    k2 = vq.size();
    add(10, 0, 1, 0, 0);
    mark(k2 + 6, 1, 0);
    add(12, 1, 1, 0, 0);
    // 6: right held through reset
    add(3, 1, 0, 0, 0);
    add(2, 1, 0, 0, 1);
    add(15, 1, 0, 0, 0);
    add(20, 1, 1, 0, 0);
    k2 = vq.size();
    add(10, 1, 0, 0, 0);
    mark(k2 + 6, 0, 1);
    add(12, 1, 1, 0, 0);
    // 7: game_over rises while left held
    k = vq.size();
    add(10, 0, 1, 0, 0);
    mark(k + 6, 1, 0);
    add(3, 0, 1, 1, 0);
    add(8, 0, 1, 0, 0);
    add(20, 1, 1, 0, 0);
    k2 = vq.size();
    add(10, 0, 1, 0, 0);
    mark(k2 + 6, 1, 0);
    add(12, 1, 1, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      key_l_n   = vq[i].kl;
      key_r_n   = vq[i].kr;
      game_over = vq[i].go;
      reset     = vq[i].rst;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_L", i), int'(L), int'(vq[i].el));
      chk($sformatf("vec%0d_R", i), int'(R), int'(vq[i].er));
    end

    // Shortest press that must still register: four low samples
    first = -1;
    hits  = 0;
    key_l_n = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 3) key_l_n = 1'b1;
      if (L === 1'b1) begin
        hits++;
        if (first < 0) first = e;
      end
    end
    chk("min_press_latency", first, 6);
    chk("min_press_count", hits, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
